// File: rtl/relu_pool_ctrl.sv
// relu_pool_ctrl: sequencer for the ReLU + 2x2 max-pool datapath.
// Takes one layer command, streams PE pixels into the pool stage channel by
// channel, flushes the pool pipeline at each channel end, and emits write
// enables with linear addresses into the output feature buffer.
// Optional build macro RELU_POOL_CHECK_EN adds a pool_dout_start input and a
// sticky err output that cross-checks write timing against the datapath.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; latches layer_sel / num_channels
// LOAD   | clears counters and address; skips straight to DONE if 0 channels
// STREAM | accepts PE pixels; tags bottom-right pixel of each 2x2 window
// DRAIN  | POOL_LATENCY flush cycles to push the last window out
// DONE   | one-cycle done pulse
module relu_pool_ctrl #(
   parameter int FMAP_L1      = 28,
   parameter int FMAP_L2      = 10,
   parameter int POOL_LATENCY = 3,
   parameter int ADDR_W       = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              layer_sel,
   input  logic [4:0]        num_channels,
   input  logic              src_valid,
   output logic              src_ready,
   output logic              pool_rd_en,
   output logic              flush,
   output logic [4:0]        featmap_size,
   output logic              convlayer_state,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [4:0]        channel_idx,
   output logic              busy,
   output logic              done
`ifdef RELU_POOL_CHECK_EN
   ,
   input  logic              pool_dout_start,
   output logic              err
`endif
);

   localparam int DW = $clog2(POOL_LATENCY + 1);

   typedef enum logic [2:0] {IDLE, LOAD, STREAM, DRAIN, DONE} state_t;

   state_t                  state;
   logic [4:0]              num_ch;
   logic [4:0]              col;
   logic [4:0]              row;
   logic [DW-1:0]           drain_cnt;
   logic [POOL_LATENCY-1:0] tag;
   logic [POOL_LATENCY:0]   tag_ext;
   logic [4:0]              fm_last;
   logic                    accept;
   logic                    tag_in;
   logic                    drain_last;
   logic                    last_channel;

   assign fm_last      = featmap_size - 5'd1;
   assign accept       = src_ready & src_valid;
   // A window completes on the pixel at odd row and odd column.
   assign tag_in       = accept & row[0] & col[0];
   assign tag_ext      = {tag, tag_in};
   assign pool_rd_en   = accept | flush;
   assign wr_en        = pool_rd_en & tag[POOL_LATENCY-1];
   assign drain_last   = (state == DRAIN) && (drain_cnt == DW'(1));
   assign last_channel = (channel_idx == (num_ch - 5'd1));

   // Main sequencer: state, counters, tag pipeline and registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         num_ch          <= '0;
         col             <= '0;
         row             <= '0;
         drain_cnt       <= '0;
         tag             <= '0;
         featmap_size    <= '0;
         convlayer_state <= 1'b0;
         wr_addr         <= '0;
         channel_idx     <= '0;
         src_ready       <= 1'b0;
         flush           <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
      end else begin
         done <= 1'b0;
         if (pool_rd_en) tag <= tag_ext[POOL_LATENCY-1:0];
         if (wr_en) wr_addr <= wr_addr + 1'b1;
         case (state)
            IDLE: begin
               if (start) begin
                  convlayer_state <= layer_sel;
                  num_ch          <= num_channels;
                  featmap_size    <= layer_sel ? 5'(FMAP_L2) : 5'(FMAP_L1);
                  busy            <= 1'b1;
                  state           <= LOAD;
               end
            end
            LOAD: begin
               col         <= '0;
               row         <= '0;
               channel_idx <= '0;
               wr_addr     <= '0;
               if (num_ch == 5'd0) begin
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  src_ready <= 1'b1;
                  state     <= STREAM;
               end
            end
            STREAM: begin
               if (src_valid) begin
                  if (col == fm_last) begin
                     col <= '0;
                     row <= row + 5'd1;
                  end else begin
                     col <= col + 5'd1;
                  end
                  if ((row == fm_last) && (col == fm_last)) begin
                     src_ready <= 1'b0;
                     flush     <= 1'b1;
                     drain_cnt <= DW'(POOL_LATENCY);
                     state     <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               drain_cnt <= drain_cnt - DW'(1);
               if (drain_cnt == DW'(1)) begin
                  flush <= 1'b0;
                  if (last_channel) begin
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     channel_idx <= channel_idx + 5'd1;
                     row         <= '0;
                     col         <= '0;
                     src_ready   <= 1'b1;
                     state       <= STREAM;
                  end
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef RELU_POOL_CHECK_EN
   logic first_pend;

   // Sticky check: datapath output-start must coincide with each channel's first write.
   always_ff @(posedge clk) begin
      if (rst) begin
         err        <= 1'b0;
         first_pend <= 1'b0;
      end else if (state == LOAD) begin
         err        <= 1'b0;
         first_pend <= 1'b1;
      end else begin
         if (wr_en) first_pend <= 1'b0;
         if (drain_last && !last_channel) first_pend <= 1'b1;
         if ((pool_dout_start && !wr_en) || (wr_en && first_pend && !pool_dout_start))
            err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_relu_pool_ctrl.sv
// Bench for relu_pool_ctrl: table of layer commands run against an
// independent phase model plus a write scoreboard, then hand sequences
// for mid-layer reset and (when built with the check macro) err behaviour.
module tb_relu_pool_ctrl;
   localparam int L  = 3;
   localparam int AW = 11;

   localparam int M_LOAD   = 0;
   localparam int M_STREAM = 1;
   localparam int M_DRAIN  = 2;
   localparam int M_DONE   = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          layer_sel;
   logic [4:0]    num_channels;
   logic          src_valid;
   logic          src_ready;
   logic          pool_rd_en;
   logic          flush;
   logic [4:0]    featmap_size;
   logic          convlayer_state;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [4:0]    channel_idx;
   logic          busy;
   logic          done;
`ifdef RELU_POOL_CHECK_EN
   logic          pool_dout_start;
   logic          err;
`endif

   relu_pool_ctrl #(
      .FMAP_L1(28), .FMAP_L2(10), .POOL_LATENCY(L), .ADDR_W(AW)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .layer_sel(layer_sel),
      .num_channels(num_channels), .src_valid(src_valid), .src_ready(src_ready),
      .pool_rd_en(pool_rd_en), .flush(flush), .featmap_size(featmap_size),
      .convlayer_state(convlayer_state), .wr_en(wr_en), .wr_addr(wr_addr),
      .channel_idx(channel_idx), .busy(busy), .done(done)
`ifdef RELU_POOL_CHECK_EN
      , .pool_dout_start(pool_dout_start), .err(err)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int addr;
      int due;
   } exp_t;
   exp_t sbq[$];

   typedef struct {
      logic lay;
      int   nch;
      bit   rnd;
      bit   xstart;
      int   exp_wr;
   } vec_t;
   vec_t vecs[6];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         if (bad <= 40) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic run_cmd(input logic lay, input int nch, input bit rnd, input bit xstart,
                          input int chkmode, output int nwr);
      int   f, per, cyc, acc_ch, ch, rdc, addr_exp, dcnt, mph;
      bit   fin, late_pend, exp_rdy, exp_fl, exp_rd, exp_wr;
      exp_t e;
      f = lay ? 10 : 28;
      per = (f / 2) * (f / 2);
      cyc = 0; acc_ch = 0; ch = 0; rdc = 0; addr_exp = 0; dcnt = 0;
      mph = M_LOAD; fin = 0; late_pend = 0; nwr = 0;
      sbq.delete();
      @(posedge clk); #1;
      layer_sel = lay; num_channels = nch[4:0]; start = 1'b1; src_valid = 1'b0;
      @(posedge clk); #1;
      start = 1'b0; layer_sel = ~lay; num_channels = 5'd7;
      while (!fin && cyc < 40000) begin
         cyc++;
         src_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         start = (xstart && cyc == 50) ? 1'b1 : 1'b0;
         #1;
`ifdef RELU_POOL_CHECK_EN
         pool_dout_start = late_pend;
         late_pend = 1'b0;
         if (wr_en && sbq.size() > 0 && (sbq[0].addr % per) == 0) begin
            if (chkmode == 1) pool_dout_start = 1'b1;
            if (chkmode == 2) late_pend = 1'b1;
         end
`endif
         @(negedge clk);
         exp_rdy = (mph == M_STREAM);
         exp_fl  = (mph == M_DRAIN);
         exp_rd  = (exp_rdy && src_valid) || exp_fl;
         exp_wr  = exp_rd && sbq.size() > 0 && sbq[0].due == rdc;
         chk("busy", int'(busy), 1);
         chk("featmap_size", int'(featmap_size), f);
         chk("convlayer_state", int'(convlayer_state), int'(lay));
         chk("src_ready", int'(src_ready), int'(exp_rdy));
         chk("flush", int'(flush), int'(exp_fl));
         chk("pool_rd_en", int'(pool_rd_en), int'(exp_rd));
         chk("done", int'(done), int'(mph == M_DONE));
         if (exp_rdy || exp_fl) chk("channel_idx", int'(channel_idx), ch);
         chk("wr_en", int'(wr_en), int'(exp_wr));
         if (wr_en) nwr++;
         if (exp_wr) begin
            e = sbq.pop_front();
            chk("wr_addr", int'(wr_addr), e.addr % (1 << AW));
         end
         case (mph)
            M_LOAD: mph = (nch == 0) ? M_DONE : M_STREAM;
            M_STREAM: begin
               if (src_valid) begin
                  if (((acc_ch / f) % 2 == 1) && ((acc_ch % f) % 2 == 1)) begin
                     e.addr = addr_exp; e.due = rdc + L;
                     sbq.push_back(e);
                     addr_exp++;
                  end
                  acc_ch++;
                  if (acc_ch == f * f) begin
                     mph = M_DRAIN;
                     dcnt = L;
                  end
               end
            end
            M_DRAIN: begin
               dcnt--;
               if (dcnt == 0) begin
                  if (ch == nch - 1) mph = M_DONE;
                  else begin
                     ch++; acc_ch = 0; mph = M_STREAM;
                  end
               end
            end
            default: fin = 1;
         endcase
         if (exp_rd) rdc++;
         @(posedge clk); #1;
      end
      src_valid = 1'b0; start = 1'b0;
`ifdef RELU_POOL_CHECK_EN
      pool_dout_start = 1'b0;
`endif
      chk("cmd_finished_in_budget", int'(fin), 1);
      chk("scoreboard_empty", sbq.size(), 0);
      @(negedge clk);
      chk("busy_after_done", int'(busy), 0);
      chk("done_single", int'(done), 0);
      chk("featmap_hold", int'(featmap_size), f);
      if (xstart) begin
         repeat (4) @(negedge clk);
         chk("no_second_cmd", int'(busy), 0);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int nwr;
      int waitc;
      vecs[0] = '{lay: 1'b0, nch: 1,  rnd: 1'b0, xstart: 1'b0, exp_wr: 196};
      vecs[1] = '{lay: 1'b1, nch: 16, rnd: 1'b0, xstart: 1'b0, exp_wr: 400};
      vecs[2] = '{lay: 1'b1, nch: 1,  rnd: 1'b1, xstart: 1'b0, exp_wr: 25};
      vecs[3] = '{lay: 1'b0, nch: 0,  rnd: 1'b0, xstart: 1'b0, exp_wr: 0};
      vecs[4] = '{lay: 1'b0, nch: 1,  rnd: 1'b0, xstart: 1'b1, exp_wr: 196};
      vecs[5] = '{lay: 1'b1, nch: 3,  rnd: 1'b1, xstart: 1'b0, exp_wr: 75};

      rst = 1'b1; start = 1'b0; layer_sel = 1'b0; num_channels = '0; src_valid = 1'b0;
`ifdef RELU_POOL_CHECK_EN
      pool_dout_start = 1'b0;
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_wr_addr", int'(wr_addr), 0);
      chk("rst_featmap", int'(featmap_size), 0);
      chk("rst_src_ready", int'(src_ready), 0);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         run_cmd(vecs[i].lay, vecs[i].nch, vecs[i].rnd, vecs[i].xstart, 1, nwr);
         chk($sformatf("wr_count_vec%0d", i), nwr, vecs[i].exp_wr);
      end

      // Mid-layer reset during conv1 channel 3.
      @(posedge clk); #1;
      layer_sel = 1'b0; num_channels = 5'd5; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; src_valid = 1'b1;
      waitc = 0;
      @(negedge clk);
      while (!(channel_idx == 5'd3 && src_ready) && waitc < 10000) begin
         waitc++;
         @(negedge clk);
      end
      chk("reach_channel3", int'(channel_idx == 5'd3 && src_ready), 1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_src_ready", int'(src_ready), 0);
      chk("mid_rst_pool_rd_en", int'(pool_rd_en), 0);
      chk("mid_rst_flush", int'(flush), 0);
      chk("mid_rst_wr_en", int'(wr_en), 0);
      chk("mid_rst_wr_addr", int'(wr_addr), 0);
      chk("mid_rst_channel_idx", int'(channel_idx), 0);
      chk("mid_rst_featmap", int'(featmap_size), 0);
      chk("mid_rst_convlayer", int'(convlayer_state), 0);
      @(posedge clk); #1;
      rst = 1'b0; src_valid = 1'b0;
      run_cmd(1'b1, 1, 1'b0, 1'b0, 1, nwr);
      chk("post_rst_wr_count", nwr, 25);

`ifdef RELU_POOL_CHECK_EN
      run_cmd(1'b1, 2, 1'b1, 1'b0, 1, nwr);
      chk("err_aligned", int'(err), 0);
      run_cmd(1'b1, 1, 1'b0, 1'b0, 2, nwr);
      chk("err_late", int'(err), 1);
      repeat (3) @(negedge clk);
      chk("err_sticky", int'(err), 1);
      run_cmd(1'b1, 1, 1'b0, 1'b0, 1, nwr);
      chk("err_cleared_by_load", int'(err), 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
